lstm_bptt_seq_ctrl: RTL
=======================

Name: lstm_bptt_seq_ctrl

Overview:
Sequencer for the enable-controlled timestep shift register that stores per-timestep LSTM activations. On start it clears the register, then gates its shift enable for exactly NUM_ITERATIONS forward results. It then walks the stored timesteps in reverse order (t = N-1 down to 0) toward the backpropagation-through-time datapath with a valid/ready handshake. It sits between the forward-propagation top level, the shift register and the BPTT unit.

Parameters:
NUM_ITERATIONS, 68, number of timesteps per sequence (N); must be >= 2
CNT_W, 7, width of timestep counters; must satisfy 2^CNT_W >= NUM_ITERATIONS

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous active-high reset
start  input  1  begin a sequence; honoured only in IDLE
abort  input  1  return to IDLE from any state
fwd_valid  input  1  forward datapath presents one timestep result this cycle
fwd_ready  output  1  controller accepting forward results (= state FWD)
sr_clr  output  1  one-cycle clear pulse to the shift register
sr_en  output  1  shift enable to the shift register
fwd_idx  output  CNT_W  index of the timestep being captured
bwd_valid  output  1  a stored timestep is offered to BPTT
bwd_ready  input  1  BPTT consumes the offered timestep
bwd_idx  output  CNT_W  slot index (timestep) offered, N-1 down to 0
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle pulse after the last backward transfer

Behaviour:
- States: IDLE, FWD, BWD, DONE. Reset → IDLE, fwd_idx=0, bwd_idx=0, and all control outputs low. rst has priority over all inputs.
- IDLE: start=1 → next cycle FWD, fwd_idx=0. sr_clr is asserted combinationally in the same cycle start is accepted (1-cycle pulse).
- FWD: fwd_ready=1; sr_en = fwd_valid (combinational, same cycle, no latency).
- FWD, each cycle with fwd_valid=1: fwd_idx increments.
- FWD, fwd_valid=1 with fwd_idx==N-1: go to BWD next cycle with bwd_idx=N-1, and fwd_idx holds at N-1.
- FWD, fwd_valid=0: state and counters hold.
- BWD: bwd_valid=1; sr_en=0 and fwd_ready=0.
- BWD, transfer (bwd_valid & bwd_ready): if bwd_idx==0 → DONE, else bwd_idx decrements.
- BWD, no transfer: bwd_idx holds; bwd_valid stays high with a stable index.
- DONE: done=1 for exactly one cycle, then IDLE; fwd_idx and bwd_idx cleared to 0 on entry to IDLE.
- abort=1 in any non-IDLE state: next state IDLE, counters cleared, no done pulse. In that cycle sr_en=0, bwd_valid=0 and fwd_ready=0 (abort masks them combinationally). abort in IDLE has no effect.
- abort and start together in IDLE: start wins.
- start outside IDLE is ignored. fwd_valid outside FWD is ignored (sr_en stays 0). bwd_ready outside BWD is ignored.
- Storage ordering: each shift inserts at the top slot. After N shifts, slot k holds timestep k, so the BPTT reads slot bwd_idx.
- Totals per sequence: exactly N sr_en pulses, exactly N backward transfers, and one done pulse.

Test Plan:
- N=4, start, fwd_valid held high 4 cycles, bwd_ready held high → sr_clr pulses once; sr_en high 4 cycles with fwd_idx 0,1,2,3; BWD offers bwd_idx 3,2,1,0 on consecutive cycles; done pulses once; busy low afterward; total 10 cycles from start to IDLE.
- N=4, fwd_valid pattern 1,0,0,1,1,0,1 → sr_en mirrors fwd_valid exactly; BWD entered only after the 4th valid.
- BWD with bwd_ready pattern 0,1,0,0,1,1,1 → bwd_idx holds during stalls; sequence 3,3,2,2,2,1,0; done one cycle after the 0 transfer.
- abort asserted after 2 forward captures → same cycle: sr_en=0 and fwd_ready=0; next cycle: IDLE, busy=0, fwd_idx=0, no done; a following start restarts cleanly with an sr_clr pulse.
- start asserted during FWD/BWD and fwd_valid asserted in IDLE/BWD → no state change, no sr_en.
- rst asserted mid-BWD (bwd_idx=2) → next cycle IDLE with all outputs and counters 0; rst with start held high → stays IDLE while rst is high.

Source files
------------

// File: rtl/lstm_bptt_seq_ctrl.sv
// Sequencer for the LSTM timestep shift register: clears it, gates N forward
// shifts, then offers stored timesteps N-1..0 to the BPTT unit over valid/ready.
module lstm_bptt_seq_ctrl #(
  parameter int NUM_ITERATIONS = 68,
  parameter int CNT_W          = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             fwd_valid,
  output logic             fwd_ready,
  output logic             sr_clr,
  output logic             sr_en,
  output logic [CNT_W-1:0] fwd_idx,
  output logic             bwd_valid,
  input  logic             bwd_ready,
  output logic [CNT_W-1:0] bwd_idx,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FWD  = 2'd1,
    BWD  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_ITERATIONS - 1);

  state_t state;

  // Handshake outputs are combinational so the shift register and BPTT see
  // enables in the same cycle as the data; abort masks them immediately.
  assign fwd_ready = (state == FWD) && !abort;
  assign sr_en     = fwd_ready && fwd_valid;
  assign bwd_valid = (state == BWD) && !abort;
  assign sr_clr    = (state == IDLE) && start && !rst;
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      fwd_idx <= '0;
      bwd_idx <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state   <= FWD;
            fwd_idx <= '0;
            bwd_idx <= '0;
          end
        end
        FWD: begin
          if (abort) begin
            state   <= IDLE;
            fwd_idx <= '0;
            bwd_idx <= '0;
          end else if (fwd_valid) begin
            if (fwd_idx == LAST_IDX) begin
              // fwd_idx parks at N-1; slot k now holds timestep k
              state   <= BWD;
              bwd_idx <= LAST_IDX;
            end else begin
              fwd_idx <= fwd_idx + CNT_W'(1);
            end
          end
        end
        BWD: begin
          if (abort) begin
            state   <= IDLE;
            fwd_idx <= '0;
            bwd_idx <= '0;
          end else if (bwd_ready) begin
            if (bwd_idx == '0) begin
              state <= DONE;
            end else begin
              bwd_idx <= bwd_idx - CNT_W'(1);
            end
          end
        end
        DONE: begin
          state   <= IDLE;
          fwd_idx <= '0;
          bwd_idx <= '0;
        end
        default: begin
          state   <= IDLE;
          fwd_idx <= '0;
          bwd_idx <= '0;
        end
      endcase
    end
  end

endmodule
